// File: rtl/nv_ram_rws_fifo_rd.sv
// nv_ram_rws_fifo_rd: valid/ready FIFO over a dual-port register file.
// Read side issues re/ra with one-cycle latency and holds ra_d on stall.
module nv_ram_rws_fifo_rd #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int WIDTH = 1088
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [AW:0]      count,
  input  logic [31:0]      pwrbus_ram_pd
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] ra_d;
  logic [AW:0]   ram_cnt;
  logic          out_vld;

  logic push;
  logic pop;
  logic re;

  // The power bus only matters to real RAM macros.
  logic unused_pwrbus;
  assign unused_pwrbus = ^pwrbus_ram_pd;

  // Handshakes and read-issue decision.
  assign wr_prdy = (count != CNT_FULL);
  assign push    = wr_pvld & wr_prdy;
  assign rd_pvld = out_vld;
  assign pop     = out_vld & rd_prdy;
  assign re      = (ram_cnt != '0) & (~out_vld | rd_prdy);

  // Array output is combinational from the registered read address.
  assign rd_pd = mem[ra_d];

  // Storage array write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_pd;
    end
  end

  // Write pointer advances on every accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Read pointer and registered read address advance on read issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      ra_d   <= '0;
    end else if (re) begin
      rd_ptr <= rd_ptr + PTR_ONE;
      ra_d   <= rd_ptr;
    end
  end

  // Output valid: set by an issue, cleared by a pop without a refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
    end else if (re) begin
      out_vld <= 1'b1;
    end else if (pop) begin
      out_vld <= 1'b0;
    end
  end

  // Entries written into the array but not yet issued for read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_cnt <= '0;
    end else begin
      unique case ({push, re})
        2'b10:   ram_cnt <= ram_cnt + CNT_ONE;
        2'b01:   ram_cnt <= ram_cnt - CNT_ONE;
        default: ram_cnt <= ram_cnt;
      endcase
    end
  end

  // Occupancy: accepted and not yet popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/nv_ram_rws_fifo_rd.md
# nv_ram_rws_fifo_rd

Valid/ready FIFO that drives an internal 64-entry dual-port register-file array as both writer and reader. It issues the array's read-enable and read-address, holds the registered read address, and presents the array's combinational output as a valid/ready read interface. It is the client-side counterpart of the NVDLA `rws` RAM models: it implements the read-enable, registered-address, one-cycle-latency protocol from the consuming end. It sits between a producer and a consumer in NVDLA datapath buffering, for example CDMA or CACC line staging.

## Interface
Parameters:
- DEPTH, 64, number of entries; power of two, at least 4.
- AW, 6, address width; equals log2(DEPTH).
- WIDTH, 1088, payload width in bits.

Ports:
- clk  in  1  single clock; everything is on posedge.
- rst  in  1  asynchronous, active-high reset.
- wr_pvld  in  1  producer has data.
- wr_prdy  out  1  FIFO can accept data.
- wr_pd  in  WIDTH  write payload.
- rd_pvld  out  1  read data valid.
- rd_prdy  in  1  consumer accepts.
- rd_pd  out  WIDTH  read payload.
- count  out  AW+1  entries accepted and not yet popped, range 0..DEPTH.
- pwrbus_ram_pd  in  32  power-down bus; ignored by the block, no functional effect.

## Operation
- Storage: array M[DEPTH] of WIDTH bits, not reset.
- Control state (all reset to 0 asynchronously):
  - wr_ptr[AW-1:0]
  - rd_ptr[AW-1:0]
  - ra_d[AW-1:0]
  - ram_cnt[AW:0]: written but not yet read-issued.
  - count[AW:0]
  - out_vld
- Push condition: push = wr_pvld & wr_prdy.
  - wr_prdy = (count != DEPTH).
  - On push: M[wr_ptr] <= wr_pd, and wr_ptr increments, wrapping DEPTH-1 -> 0.
- Pop condition: pop = rd_pvld & rd_prdy.
  - rd_pvld = out_vld.
  - rd_pd = M[ra_d], combinational from the array.
- Read issue condition: re = (ram_cnt != 0) & (!out_vld | rd_prdy).
  - On re: ra_d <= rd_ptr, and rd_ptr increments with wrap.
  - ra_d holds whenever re is low, so rd_pd stays stable while stalled.
- out_vld next value:
  - re -> 1
  - else pop -> 0
  - else hold
- ram_cnt next value: ram_cnt + push - re.
- count next value: count + push - pop. Simultaneous push and pop leaves it unchanged.
- Overwrite safety: an entry stays in count until popped. wr_ptr therefore never reaches the slot currently addressed by ra_d while it is valid, and no write/read bypass is needed.
- Read issue only addresses slots written on an earlier edge. Same-cycle write-then-read of one slot never occurs.
- Full with pop: wr_prdy stays 0 in that cycle (no full-bypass). Push is accepted the cycle after count drops.
- Empty with push: there is no write-to-read bypass; see latency below.
- wr_pd is don't-care when push=0. rd_prdy is don't-care when rd_pvld=0.

## Timing
- Reset values:
  - rd_pvld=0, count=0, wr_prdy=1.
  - wr_prdy is 1 during reset as well.
  - rd_pd is undefined until the first rd_pvld.
- Reset mid-operation: all pointers, counters and out_vld clear immediately. Contents are discarded and the array is not cleared.
- Empty-FIFO latency:
  - push in cycle n -> re in n+1 -> rd_pvld=1 in n+2.
  - count=1 from n+1.
- Throughput: one push and one pop per cycle sustained, with rd_prdy held at 1 and the FIFO non-empty.
- Backpressure: with rd_prdy=0, rd_pd and rd_pvld hold. Pushes continue until count=DEPTH, then wr_prdy=0.
- count is registered; it changes on the edge after the push or pop.

## Test plan
- Reset then idle: after rst deasserts, rd_pvld=0, wr_prdy=1, count=0 for 10 cycles.
- Single entry:
  - push 0xA5 (zero-extended) in cycle 0 -> count=1 in cycle 1, rd_pvld=1 and rd_pd=0xA5 in cycle 2.
  - pop in cycle 2 -> rd_pvld=0 and count=0 in cycle 3.
- Fill to full:
  - 64 back-to-back pushes of values 0..63 with rd_prdy=0 -> count=64 and wr_prdy=0.
  - A 65th push attempt is not accepted.
  - Draining then yields 0..63 in order, with count reaching 0.
- Full with simultaneous pop: at count=64, assert pop with wr_pvld=1 -> count=63 next cycle, push accepted only in the following cycle, and order is preserved.
- Streaming with wrap: push 200 incrementing values while randomly toggling rd_prdy -> output sequence equals input sequence, and count never exceeds 64.
- Reset mid-stream: at count=30, pulse rst -> count=0 and rd_pvld=0 immediately. A subsequent push of 0x1 reads back 0x1 only.
